// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: shares one memory port among N_CH requesters (channel 0 = CPU).
// Round-robin arbitration with burst hold and an optional fixed priority for channel 0.
// Only one memory access is in flight at a time.
// Optional feature: define ARB_TIMEOUT_EN to end an access that gets no mem_ack
// within TO_CYC cycles with an error response.
`timescale 1ns/1ps
module mem_arbiter_rr #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned PRIO0     = 1,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned TO_CYC    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    ch_req,
  input  logic [N_CH-1:0]    ch_we,
  input  logic [N_CH*AW-1:0] ch_addr,
  input  logic [N_CH*DW-1:0] ch_wdata,
  output logic [N_CH-1:0]    ch_resp,
  output logic [DW-1:0]      ch_rdata,
  output logic [N_CH-1:0]    ch_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic               mem_ack,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam int unsigned TW = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_grant, w_grant_nxt;
  logic            r_prio_win, w_prio_win_nxt;
  logic            r_same, w_same_nxt;
  logic [CW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [BW-1:0]   r_burst_cnt, w_burst_nxt;
  logic [TW-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic            r_mem_req, w_mem_req_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [N_CH-1:0] r_ch_resp, w_ch_resp_nxt;
  logic [DW-1:0]   r_ch_rdata, w_ch_rdata_nxt;
`ifdef ARB_TIMEOUT_EN
  logic [N_CH-1:0] r_ch_err, w_ch_err_nxt;
`endif

  logic [CW:0]     w_sum;
  logic            w_rr_hit;
  logic [CW-1:0]   w_rr_win;
  logic            w_hold;
  logic            w_prio;
  logic [CW-1:0]   w_win;
  logic [N_CH-1:0] w_onehot;

  assign w_onehot = N_CH'(1) << r_grant;

  // Winner selection: channel 0 priority, then burst hold, then round-robin scan from r_rr_ptr
  always_comb begin
    w_sum    = '0;
    w_rr_hit = 1'b0;
    w_rr_win = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      w_sum = {1'b0, r_rr_ptr} + (CW+1)'(k);
      if (w_sum >= (CW+1)'(N_CH)) w_sum = w_sum - (CW+1)'(N_CH);
      if (!w_rr_hit && ch_req[w_sum[CW-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_win = w_sum[CW-1:0];
      end
    end
    w_hold = ch_req[r_grant] && (r_burst_cnt < BW'(BURST_MAX));
    w_prio = (PRIO0 != 0) && ch_req[0];
    if (w_prio)      w_win = '0;
    else if (w_hold) w_win = r_grant;
    else             w_win = w_rr_win;
  end

  // Next-state and next register values
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_prio_win_nxt  = r_prio_win;
    w_same_nxt      = r_same;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_nxt     = r_burst_cnt;
    w_to_cnt_nxt    = r_to_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_ch_resp_nxt   = r_ch_resp;
    w_ch_rdata_nxt  = r_ch_rdata;
`ifdef ARB_TIMEOUT_EN
    w_ch_err_nxt    = r_ch_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (|ch_req) begin
          w_grant_nxt     = w_win;
          w_prio_win_nxt  = w_prio;
          // A burst continues only while the same channel wins below the hold limit
          w_same_nxt      = (w_win == r_grant) && (r_burst_cnt != '0) &&
                            (r_burst_cnt < BW'(BURST_MAX));
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = ch_we[w_win];
          w_mem_addr_nxt  = ch_addr[int'(w_win)*AW +: AW];
          w_mem_wdata_nxt = ch_wdata[int'(w_win)*DW +: DW];
          w_to_cnt_nxt    = '0;
          w_state_nxt     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_to_cnt_nxt = r_to_cnt + TW'(1);
        if (mem_ack) begin
          w_ch_rdata_nxt = mem_rdata;
          w_ch_resp_nxt  = w_onehot;
          w_mem_req_nxt  = 1'b0;
          w_state_nxt    = S_RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_to_cnt == TW'(TO_CYC - 1)) begin
          w_ch_rdata_nxt = {DW{1'b1}};
          w_ch_resp_nxt  = w_onehot;
          w_ch_err_nxt   = w_onehot;
          w_mem_req_nxt  = 1'b0;
          w_state_nxt    = S_RESP;
        end
`endif
      end
      S_RESP: begin
        w_ch_resp_nxt = '0;
`ifdef ARB_TIMEOUT_EN
        w_ch_err_nxt  = '0;
`endif
        w_burst_nxt   = r_same ? (r_burst_cnt + BW'(1)) : BW'(1);
        if (r_prio_win || (w_burst_nxt >= BW'(BURST_MAX)))
          w_rr_ptr_nxt = (r_grant == CW'(N_CH - 1)) ? '0 : (r_grant + CW'(1));
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_prio_win  <= 1'b0;
      r_same      <= 1'b0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_to_cnt    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ch_resp   <= '0;
      r_ch_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      r_ch_err    <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_prio_win  <= w_prio_win_nxt;
      r_same      <= w_same_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_ch_resp   <= w_ch_resp_nxt;
      r_ch_rdata  <= w_ch_rdata_nxt;
`ifdef ARB_TIMEOUT_EN
      r_ch_err    <= w_ch_err_nxt;
`endif
    end
  end

  assign ch_resp   = r_ch_resp;
  assign ch_rdata  = r_ch_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
`ifdef ARB_TIMEOUT_EN
  assign ch_err    = r_ch_err;
`else
  assign ch_err    = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed tests for mem_arbiter_rr.
// dut_a: PRIO0=0, BURST_MAX=1; dut_b: PRIO0=1, BURST_MAX=4; both TO_CYC=8.
`timescale 1ns/1ps
module tb_mem_arbiter_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    ch_req, ch_we;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_wdata;

  logic [N-1:0]  a_resp, b_resp, a_err, b_err;
  logic [DW-1:0] a_rdata, b_rdata, a_wdata, b_wdata;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_mreq, b_mreq, a_we, b_we, a_ack, b_ack;

  int            lat = 1;
  logic          ack_en = 1'b1;
  logic [DW-1:0] rd_val = '0;
  int            a_cnt = 0, b_cnt = 0;

  mem_arbiter_rr #(.N_CH(N), .AW(AW), .DW(DW), .PRIO0(0), .BURST_MAX(1), .TO_CYC(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_resp(a_resp), .ch_rdata(a_rdata), .ch_err(a_err),
    .mem_req(a_mreq), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_ack(a_ack), .mem_rdata(rd_val));

  mem_arbiter_rr #(.N_CH(N), .AW(AW), .DW(DW), .PRIO0(1), .BURST_MAX(4), .TO_CYC(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_resp(b_resp), .ch_rdata(b_rdata), .ch_err(b_err),
    .mem_req(b_mreq), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_ack(b_ack), .mem_rdata(rd_val));

  // Memory model: ack after lat cycles of mem_req
  always @(posedge clk) begin
    a_cnt <= (a_mreq && !a_ack) ? a_cnt + 1 : 0;
    b_cnt <= (b_mreq && !b_ack) ? b_cnt + 1 : 0;
  end
  assign a_ack = a_mreq && ack_en && (a_cnt == lat - 1);
  assign b_ack = b_mreq && ack_en && (b_cnt == lat - 1);

  // Observation mux: sel=0 watches dut_a, sel=1 watches dut_b
  logic          sel = 1'b0;
  logic [N-1:0]  o_resp, o_err;
  logic [DW-1:0] o_rdata, o_wdata;
  logic [AW-1:0] o_addr;
  logic          o_mreq, o_we;
  assign o_resp  = sel ? b_resp  : a_resp;
  assign o_err   = sel ? b_err   : a_err;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_mreq  = sel ? b_mreq  : a_mreq;
  assign o_we    = sel ? b_we    : a_we;

  int n_cmp = 0;
  int n_bad = 0;

  int            rem [N];
  int            resp_log[$];
  int            step_log[$];
  logic [DW-1:0] rdata_log[$];
  logic [N-1:0]  err_log[$];
  logic [N-1:0]  raw_log[$];
  int            req_cyc;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic          last_we;

  task automatic clear_log();
    resp_log.delete(); step_log.delete(); rdata_log.delete();
    err_log.delete(); raw_log.delete();
    req_cyc = 0; last_addr = '0; last_wdata = '0; last_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    for (int i = 0; i < int'(N); i++) rem[i] = 0;
    ack_en = 1'b1; lat = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
  endtask

  task automatic setup_ch(input int ch, input int n, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    rem[ch] = n;
    ch_req[ch] = (n > 0);
    ch_we[ch] = we;
    ch_addr[ch*AW +: AW] = addr;
    ch_wdata[ch*DW +: DW] = wd;
  endtask

  // Requester model: each channel drops or renews its request on the edge after its ch_resp
  task automatic run(input int ncyc, input int inj_cyc, input int inj_ch);
    logic [N-1:0] pend;
    int idx;
    pend = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == inj_cyc) begin rem[inj_ch] = 1; ch_req[inj_ch] = 1'b1; end
      @(posedge clk); #1;
      for (int i = 0; i < int'(N); i++)
        if (pend[i]) begin rem[i] = rem[i] - 1; ch_req[i] = (rem[i] > 0); end
      pend = o_resp;
      if (o_resp != '0) begin
        idx = -1;
        for (int i = 0; i < int'(N); i++) if (o_resp[i]) idx = i;
        resp_log.push_back(idx); step_log.push_back(c);
        rdata_log.push_back(o_rdata); err_log.push_back(o_err); raw_log.push_back(o_resp);
      end
      if (o_mreq) begin
        req_cyc++; last_addr = o_addr; last_we = o_we; last_wdata = o_wdata;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    #3;
    n_cmp++;
    if ({a_mreq, a_we, a_addr, a_wdata, a_resp, a_rdata, a_err} !== '0) begin
      n_bad++; $display("FAIL reset_a: outputs %h, expected all zero",
                        {a_mreq, a_we, a_addr, a_wdata, a_resp, a_rdata, a_err});
    end
    n_cmp++;
    if ({b_mreq, b_we, b_addr, b_wdata, b_resp, b_rdata, b_err} !== '0) begin
      n_bad++; $display("FAIL reset_b: outputs %h, expected all zero",
                        {b_mreq, b_we, b_addr, b_wdata, b_resp, b_rdata, b_err});
    end
  endtask

  task automatic test_single_read();
    sel = 1'b0;
    do_reset();
    lat = 2; rd_val = 32'hA5A5_0001;
    setup_ch(2, 1, 1'b0, 32'h3800_0040, 32'h0);
    run(8, -1, 0);
    n_cmp++;
    if (req_cyc !== 2) begin n_bad++; $display("FAIL single_mem_req_cycles: got %0d expected 2", req_cyc); end
    n_cmp++;
    if (last_addr !== 32'h3800_0040 || last_we !== 1'b0) begin
      n_bad++; $display("FAIL single_addr_we: got %h/%b expected 38000040/0", last_addr, last_we);
    end
    n_cmp++;
    if (resp_log.size() !== 1) begin
      n_bad++; $display("FAIL single_resp_count: got %0d expected 1", resp_log.size());
    end else begin
      n_cmp++;
      if (raw_log[0] !== 4'b0100) begin n_bad++; $display("FAIL single_resp: got %b expected 0100", raw_log[0]); end
      n_cmp++;
      if (rdata_log[0] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_rdata: got %h expected a5a50001", rdata_log[0]); end
      n_cmp++;
      if (step_log[0] !== 2) begin n_bad++; $display("FAIL single_latency: got step %0d expected 2", step_log[0]); end
      n_cmp++;
      if (err_log[0] !== 4'b0000) begin n_bad++; $display("FAIL single_err: got %b expected 0000", err_log[0]); end
    end
  endtask

  task automatic test_round_robin();
    sel = 1'b0;
    do_reset();
    rd_val = 32'h1234_5678;
    for (int i = 0; i < int'(N); i++) setup_ch(i, 100, 1'b0, AW'(32'h100 * i), '0);
    run(30, -1, 0);
    n_cmp++;
    if (resp_log.size() < 8) begin
      n_bad++; $display("FAIL rr_count: got %0d responses expected at least 8", resp_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (resp_log[k] !== k % 4) begin
          n_bad++; $display("FAIL rr_order[%0d]: got ch %0d expected ch %0d", k, resp_log[k], k % 4);
        end
      end
      n_cmp++;
      if (step_log[7] !== 22) begin n_bad++; $display("FAIL rr_throughput: 8th resp at step %0d expected 22", step_log[7]); end
    end
  endtask

  task automatic test_prio0();
    int exp_q[$];
    sel = 1'b1;
    do_reset();
    setup_ch(1, 100, 1'b0, 32'h1000, '0);
    setup_ch(3, 100, 1'b0, 32'h3000, '0);
    setup_ch(0, 0, 1'b0, 32'h0000, '0);
    run(40, 16, 0);
    exp_q = '{1, 1, 1, 1, 3, 3, 0, 1, 1, 1, 1, 3};
    n_cmp++;
    if (resp_log.size() < 12) begin
      n_bad++; $display("FAIL prio_count: got %0d responses expected at least 12", resp_log.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        n_cmp++;
        if (resp_log[k] !== exp_q[k]) begin
          n_bad++; $display("FAIL prio_order[%0d]: got ch %0d expected ch %0d", k, resp_log[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_burst();
    int exp_q[$];
    sel = 1'b1;
    do_reset();
    setup_ch(2, 6, 1'b1, 32'h2000, 32'hC0DE_0002);
    setup_ch(3, 1, 1'b0, 32'h3000, '0);
    run(24, -1, 0);
    exp_q = '{2, 2, 2, 2, 3, 2, 2};
    n_cmp++;
    if (resp_log.size() !== 7) begin
      n_bad++; $display("FAIL burst_count: got %0d responses expected 7", resp_log.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        n_cmp++;
        if (resp_log[k] !== exp_q[k]) begin
          n_bad++; $display("FAIL burst_order[%0d]: got ch %0d expected ch %0d", k, resp_log[k], exp_q[k]);
        end
      end
    end
    n_cmp++;
    if (last_we !== 1'b1 || last_wdata !== 32'hC0DE_0002) begin
      n_bad++; $display("FAIL burst_wdata: got we=%b data=%h expected 1/c0de0002", last_we, last_wdata);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    sel = 1'b0;
    do_reset();
    ack_en = 1'b0;
    setup_ch(1, 1, 1'b0, 32'h1100, '0);
    run(14, -1, 0);
    n_cmp++;
    if (req_cyc !== 8) begin n_bad++; $display("FAIL to_mem_req_cycles: got %0d expected 8", req_cyc); end
    n_cmp++;
    if (resp_log.size() !== 1) begin
      n_bad++; $display("FAIL to_resp_count: got %0d expected 1", resp_log.size());
    end else begin
      n_cmp++;
      if (raw_log[0] !== 4'b0010 || err_log[0] !== 4'b0010) begin
        n_bad++; $display("FAIL to_resp_err: got resp=%b err=%b expected 0010/0010", raw_log[0], err_log[0]);
      end
      n_cmp++;
      if (rdata_log[0] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL to_rdata: got %h expected ffffffff", rdata_log[0]); end
      n_cmp++;
      if (step_log[0] !== 8) begin n_bad++; $display("FAIL to_step: got %0d expected 8", step_log[0]); end
    end
    n_cmp++;
    if (o_mreq !== 1'b0) begin n_bad++; $display("FAIL to_mem_req: got %b expected 0", o_mreq); end
  endtask
`else
  task automatic test_timeout();
    sel = 1'b0;
    do_reset();
    ack_en = 1'b0;
    setup_ch(1, 1, 1'b0, 32'h1100, '0);
    run(80, -1, 0);
    n_cmp++;
    if (resp_log.size() !== 0) begin n_bad++; $display("FAIL wait_no_resp: got %0d responses expected 0", resp_log.size()); end
    n_cmp++;
    if (o_mreq !== 1'b1 || o_err !== 4'b0000) begin
      n_bad++; $display("FAIL wait_hold: got mem_req=%b err=%b expected 1/0000", o_mreq, o_err);
    end
  endtask
`endif

  task automatic test_reset_mid_access();
    sel = 1'b1;
    do_reset();
    ack_en = 1'b0;
    setup_ch(1, 1, 1'b0, 32'h1200, '0);
    run(3, -1, 0);
    n_cmp++;
    if (o_mreq !== 1'b1) begin n_bad++; $display("FAIL rst_pre_access: mem_req %b expected 1", o_mreq); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_mreq !== 1'b0 || o_resp !== 4'b0000) begin
      n_bad++; $display("FAIL rst_async: got mem_req=%b resp=%b expected 0/0000", o_mreq, o_resp);
    end
    ch_req = '0;
    for (int i = 0; i < int'(N); i++) rem[i] = 0;
    ack_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    clear_log();
    setup_ch(3, 1, 1'b0, 32'h3300, '0);
    run(8, -1, 0);
    n_cmp++;
    if (resp_log.size() !== 1) begin
      n_bad++; $display("FAIL rst_after_count: got %0d expected 1", resp_log.size());
    end else begin
      n_cmp++;
      if (resp_log[0] !== 3 || step_log[0] !== 1) begin
        n_bad++; $display("FAIL rst_after_grant: got ch %0d at step %0d expected ch 3 at step 1", resp_log[0], step_log[0]);
      end
    end
  endtask

  initial begin
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    for (int i = 0; i < int'(N); i++) rem[i] = 0;
    clear_log();
    test_reset();
    test_single_read();
    test_round_robin();
    test_prio0();
    test_burst();
    test_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
